// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the RV32 5-stage pipeline: load-use stalls, fixed-latency
// multi-cycle EX ops and taken-branch flushes, plus a saturating stall-cycle counter.
`timescale 1ns/1ps

module hazard_stall_unit #(
    parameter int LONG_LAT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             long_op_ex,
    input  logic             branch_taken_ex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             ex_hold,
    output logic             long_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LONG = 1'b1
    } state_t;

    // LONG lasts LONG_LAT-2 cycles: issue cycle + LONG cycles + final IDLE cycle = LONG_LAT.
    // r_lat_cnt holds the LONG cycles remaining after the current one.
    localparam bit             ENTER_LONG = (LONG_LAT > 2);
    localparam logic [7:0]     LAT_LOAD   = ENTER_LONG ? 8'(LONG_LAT - 3) : 8'd0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_lat_cnt;
    logic [7:0]       w_lat_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;

    assign w_load_use = mem_read_ex && (rd_ex != 5'd0) &&
                        ((uses_rs1_id && (rd_ex == rs1_id)) ||
                         (uses_rs2_id && (rd_ex == rs2_id)));

    // NOTE: every output and next-state variable gets a default first so no path infers a latch.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        ex_hold       = 1'b0;
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        // Gating with rst_n keeps outputs at reset values while reset is held, whatever the inputs.
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (branch_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (long_op_ex) begin
                        ex_hold    = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        if (ENTER_LONG) begin
                            w_state_nxt   = S_LONG;
                            w_lat_cnt_nxt = LAT_LOAD;
                        end
                    end else if (w_load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                S_LONG: begin
                    ex_hold    = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    if (r_lat_cnt == 8'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_lat_cnt_nxt = r_lat_cnt - 8'd1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!pc_write && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign long_busy    = (r_state == S_LONG);
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomised scoreboard bench for hazard_stall_unit: a driver pushes model expectations,
// a negedge monitor pops and compares. A second instance with CNT_W=4 exercises saturation.
`timescale 1ns/1ps

module tb_hazard_stall_unit;

    localparam int LONG_LAT = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       lo;
        logic       bt;
        logic       rn;
    } stim_t;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        idex_bubble;
        logic        ifid_flush;
        logic        ex_hold;
        logic        long_busy;
        logic [31:0] cnt32;
        logic [3:0]  cnt4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        uses_rs1_id, uses_rs2_id, mem_read_ex, long_op_ex, branch_taken_ex;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, ex_hold, long_busy;
    logic [31:0] stall_cycles;
    logic        s_pc_write, s_ifid_write, s_idex_bubble, s_ifid_flush, s_ex_hold, s_long_busy;
    logic [3:0]  s_stall_cycles;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t        exp_q[$];

    // Reference model state: LONG cycles still owed, and the two stall counts.
    int          busy_left = 0;
    int unsigned m_cnt32   = 0;
    int unsigned m_cnt4    = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.LONG_LAT(LONG_LAT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .long_op_ex(long_op_ex), .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .ex_hold(ex_hold), .long_busy(long_busy),
        .stall_cycles(stall_cycles)
    );

    hazard_stall_unit #(.LONG_LAT(LONG_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .long_op_ex(long_op_ex), .branch_taken_ex(branch_taken_ex),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush),
        .ex_hold(s_ex_hold), .long_busy(s_long_busy),
        .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s    = '0;
        s.rn = 1'b1;
        return s;
    endfunction

    // Drive one cycle of stimulus, predict that cycle's outputs, then advance to next posedge+1.
    task automatic step(input stim_t s);
        exp_t e;
        logic lu;
        rs1_id = s.rs1;  rs2_id = s.rs2;  rd_ex = s.rd;
        uses_rs1_id = s.u1;  uses_rs2_id = s.u2;  mem_read_ex = s.mr;
        long_op_ex = s.lo;  branch_taken_ex = s.bt;  rst_n = s.rn;

        e = '0;
        e.pc_write   = 1'b1;
        e.ifid_write = 1'b1;
        if (!s.rn) begin
            busy_left = 0;
            m_cnt32   = 0;
            m_cnt4    = 0;
        end else begin
            lu = s.mr && (s.rd != 0) && ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
            if (busy_left > 0) begin
                e.pc_write = 1'b0;  e.ifid_write = 1'b0;
                e.ex_hold  = 1'b1;  e.long_busy  = 1'b1;
                busy_left--;
            end else if (s.bt) begin
                e.ifid_flush = 1'b1;  e.idex_bubble = 1'b1;
            end else if (s.lo) begin
                e.pc_write = 1'b0;  e.ifid_write = 1'b0;  e.ex_hold = 1'b1;
                busy_left  = LONG_LAT - 2;
            end else if (lu) begin
                e.pc_write = 1'b0;  e.ifid_write = 1'b0;  e.idex_bubble = 1'b1;
            end
        end
        e.cnt32 = m_cnt32;
        e.cnt4  = 4'(m_cnt4);
        exp_q.push_back(e);
        if (s.rn && !e.pc_write) begin
            if (m_cnt32 != 32'hFFFF_FFFF) m_cnt32++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_write",       32'(pc_write),       32'(e.pc_write));
            check("ifid_write",     32'(ifid_write),     32'(e.ifid_write));
            check("idex_bubble",    32'(idex_bubble),    32'(e.idex_bubble));
            check("ifid_flush",     32'(ifid_flush),     32'(e.ifid_flush));
            check("ex_hold",        32'(ex_hold),        32'(e.ex_hold));
            check("long_busy",      32'(long_busy),      32'(e.long_busy));
            check("stall_cycles",   stall_cycles,        e.cnt32);
            check("stall_cycles_4", 32'(s_stall_cycles), 32'(e.cnt4));
            check("sat_pc_write",   32'(s_pc_write),     32'(e.pc_write));
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        rs1_id = '0;  rs2_id = '0;  rd_ex = '0;
        uses_rs1_id = 1'b0;  uses_rs2_id = 1'b0;
        mem_read_ex = 1'b0;  long_op_ex = 1'b0;  branch_taken_ex = 1'b0;
        @(posedge clk);
        #1;

        s = nop();  s.rn = 1'b0;  step(s);
        step(nop());
        // Load-use on rs1: one stall cycle, then released.
        s = nop();  s.mr = 1'b1;  s.rd = 5'd5;  s.rs1 = 5'd5;  s.u1 = 1'b1;  step(s);
        step(nop());
        // rd_ex==0 and an unused rs2 match must not stall.
        s = nop();  s.mr = 1'b1;  s.rd = 5'd0;  s.rs1 = 5'd0;  s.u1 = 1'b1;  step(s);
        s = nop();  s.mr = 1'b1;  s.rd = 5'd7;  s.rs2 = 5'd7;  s.rs1 = 5'd3;  s.u1 = 1'b1;  step(s);
        // Multi-cycle op, then its final EX cycle.
        s = nop();  s.lo = 1'b1;  step(s);
        repeat (3) step(nop());
        // Taken branch overrides a coincident load-use.
        s = nop();  s.bt = 1'b1;  s.mr = 1'b1;  s.rd = 5'd9;  s.rs2 = 5'd9;  s.u2 = 1'b1;  step(s);
        // Reset in the 2nd LONG cycle, with a load-use pattern present during reset.
        s = nop();  s.lo = 1'b1;  step(s);
        step(nop());
        s = nop();  s.rn = 1'b0;  s.mr = 1'b1;  s.rd = 5'd4;  s.rs1 = 5'd4;  s.u1 = 1'b1;  step(s);
        step(nop());
        step(nop());
        // Continuous load-use: the 4-bit counter saturates at 15.
        s = nop();  s.mr = 1'b1;  s.rd = 5'd2;  s.rs2 = 5'd2;  s.u2 = 1'b1;
        repeat (20) step(s);
        step(nop());

        for (int i = 0; i < 800; i++) begin
            s     = nop();
            s.rd  = 5'($urandom_range(3));
            s.rs1 = 5'($urandom_range(3));
            s.rs2 = 5'($urandom_range(3));
            s.u1  = 1'($urandom);
            s.u2  = 1'($urandom);
            s.mr  = 1'($urandom);
            s.bt  = ($urandom_range(7) == 0);
            s.lo  = !s.bt && ($urandom_range(9) == 0);
            s.rn  = ($urandom_range(149) != 0);
            step(s);
        end

        @(posedge clk);
        @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
